adc_selftrig: RTL and testbench

ADC_SELFTRIG -- requirements
Module: adc_selftrig

---
 rtl/adc_selftrig.sv | 132 +++++++++++++
 tb/tb_adc_selftrig.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_selftrig.sv
// Self-triggering ADC front end: polarity/pedestal correction, threshold edge trigger,
// 32-deep pre-trigger ring buffer and header+window readout.
// Optional event counter in the header is enabled by defining ADC_SELFTRIG_EVCNT_EN.
module adc_selftrig (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] DIN,
  input  logic        INV,
  input  logic [11:0] PED,
  input  logic [11:0] THR,
  input  logic [3:0]  PRESAMP,
  input  logic [5:0]  WINLEN,
  input  logic        INHIBIT,
  output logic [15:0] DOUT,
  output logic        DVALID,
  output logic        DSTART,
  output logic        TRIG,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;

  state_t             state;
  logic [11:0]        s_q;
  logic signed [12:0] d_q;
  logic signed [12:0] ring [32];
  logic [4:0]         wr_ptr;
  logic [4:0]         rd_ptr;
  logic [5:0]         fill_cnt;
  logic               over_q;
  logic               over_prev;
  logic [5:0]         win_len;
  logic [5:0]         word_cnt;
  logic [13:0]        hdr_cnt;
  logic               over_next;
  logic               trig_ok;
  logic signed [12:0] rd_word;

  // The sample pipeline and ring contents carry no reset; only control state is cleared.
  always_ff @(posedge CLK) begin
    s_q          <= INV ? (12'd4095 - DIN) : DIN;
    d_q          <= $signed({1'b0, s_q}) - $signed({1'b0, PED});
    ring[wr_ptr] <= d_q;
  end

  assign over_next = d_q > $signed({1'b0, THR});
  assign trig_ok   = over_q && !over_prev && (state == IDLE) && !INHIBIT && fill_cnt[5];
  assign rd_word   = ring[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= 5'd0;
      fill_cnt  <= 6'd0;
      over_q    <= 1'b0;
      over_prev <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + 5'd1;
      over_q    <= over_next;
      over_prev <= over_q;
      if (!fill_cnt[5])
        fill_cnt <= fill_cnt + 6'd1;
    end
  end

`ifdef ADC_SELFTRIG_EVCNT_EN
  logic [13:0] evcnt;

  always_ff @(posedge CLK) begin
    if (RST)
      evcnt <= 14'd0;
    else if (trig_ok)
      evcnt <= evcnt + 14'd1;
  end

  assign hdr_cnt = evcnt;
`else
  assign hdr_cnt = 14'd0;
`endif

  // When the trigger is taken, the trigger sample sits one slot behind the write pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      DOUT     <= 16'd0;
      DVALID   <= 1'b0;
      DSTART   <= 1'b0;
      TRIG     <= 1'b0;
      BUSY     <= 1'b0;
      rd_ptr   <= 5'd0;
      win_len  <= 6'd1;
      word_cnt <= 6'd0;
    end else begin
      TRIG <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_ok) begin
            state    <= HEAD;
            TRIG     <= 1'b1;
            DOUT     <= {2'b10, hdr_cnt};
            DVALID   <= 1'b1;
            DSTART   <= 1'b1;
            BUSY     <= 1'b1;
            rd_ptr   <= wr_ptr - 5'd1 - {1'b0, PRESAMP};
            win_len  <= (WINLEN == 6'd0) ? 6'd1 : WINLEN;
            word_cnt <= 6'd0;
          end
        end
        HEAD: begin
          state    <= DATA;
          DOUT     <= {{3{rd_word[12]}}, rd_word};
          DSTART   <= 1'b0;
          rd_ptr   <= rd_ptr + 5'd1;
          word_cnt <= 6'd1;
        end
        DATA: begin
          if (word_cnt == win_len) begin
            state  <= IDLE;
            DOUT   <= 16'd0;
            DVALID <= 1'b0;
            BUSY   <= 1'b0;
          end else begin
            DOUT     <= {{3{rd_word[12]}}, rd_word};
            rd_ptr   <= rd_ptr + 5'd1;
            word_cnt <= word_cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_selftrig.sv
// Scoreboard bench for adc_selftrig: expected event words are queued when a stream is built
// and compared as the DUT emits them. Header counts follow ADC_SELFTRIG_EVCNT_EN.
module tb_adc_selftrig;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] DIN = 12'd100;
  logic        INV = 1'b0;
  logic [11:0] PED = 12'd100;
  logic [11:0] THR = 12'd50;
  logic [3:0]  PRESAMP = 4'd2;
  logic [5:0]  WINLEN = 6'd4;
  logic        INHIBIT = 1'b0;
  logic [15:0] DOUT;
  logic        DVALID;
  logic        DSTART;
  logic        TRIG;
  logic        BUSY;

  int          checks = 0;
  int          errors = 0;
  int          trig_cnt = 0;
  int          exp_cnt = 0;
  logic [16:0] sb[$];
  int          stim[$];
  logic [15:0] last_hdr = 16'hffff;

  adc_selftrig dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .INV(INV), .PED(PED), .THR(THR),
    .PRESAMP(PRESAMP), .WINLEN(WINLEN), .INHIBIT(INHIBIT),
    .DOUT(DOUT), .DVALID(DVALID), .DSTART(DSTART), .TRIG(TRIG), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Output monitor: pops the scoreboard on every valid word, checks idle outputs otherwise.
  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if (DVALID === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word got %h/%h exp none", DSTART, DOUT);
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          if ({DSTART, DOUT} !== e) begin
            errors++;
            $display("[TB] FAIL event_word got %h/%h exp %h/%h", DSTART, DOUT, e[16], e[15:0]);
          end
          if (DSTART === 1'b1) last_hdr = DOUT;
        end
      end else if (DOUT !== 16'd0 || DSTART !== 1'b0 || DVALID !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_outputs got dout=%h dstart=%b dvalid=%b exp 0", DOUT, DSTART, DVALID);
      end
      checks++;
      if (BUSY !== DVALID) begin
        errors++;
        $display("[TB] FAIL busy_track got %b exp %b", BUSY, DVALID);
      end
      if (TRIG === 1'b1) trig_cnt++;
    end
  end

  function automatic int d_of(input int din);
    int s;
    s = INV ? (4095 - din) : din;
    return s - int'(PED);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    sb.delete();
    exp_cnt = 0;
  endtask

  // Parameter changes can glitch the pipeline once; hold triggers off until it settles.
  task automatic settle(input int base);
    INHIBIT = 1'b1;
    repeat (6) begin
      DIN = 12'(base);
      tick();
    end
    INHIBIT = 1'b0;
  endtask

  task automatic add(input int v, input int count);
    repeat (count) stim.push_back(v);
  endtask

  task automatic expect_event(input int n, input int p, input int w);
    logic [15:0] hdr;
    int wl;
    wl = (w == 0) ? 1 : w;
`ifdef ADC_SELFTRIG_EVCNT_EN
    hdr = 16'h8000 | 16'(exp_cnt % 16384);
`else
    hdr = 16'h8000;
`endif
    sb.push_back({1'b1, hdr});
    for (int k = 0; k < wl; k++) sb.push_back({1'b0, 16'(d_of(stim[n - p + k]))});
    exp_cnt++;
  endtask

  task automatic run_part(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      DIN = 12'(stim[i]);
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (DVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_dvalid got %b exp 0", DVALID); end
    checks++; if (DSTART !== 1'b0) begin errors++; $display("[TB] FAIL reset_dstart got %b exp 0", DSTART); end
    checks++; if (TRIG !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig got %b exp 0", TRIG); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (DOUT !== 16'd0) begin errors++; $display("[TB] FAIL reset_dout got %h exp 0", DOUT); end
  endtask

  task automatic test_baseline();
    int t0;
    INV = 0; PED = 100; THR = 50; PRESAMP = 2; WINLEN = 4;
    settle(100);
    t0 = trig_cnt;
    add(100, 40); add(200, 1); add(100, 20);
    expect_event(40, 2, 4);
    run_part(0, stim.size()); stim.delete();
    checks++; if (trig_cnt - t0 != 1) begin errors++; $display("[TB] FAIL baseline_trigs got %0d exp 1", trig_cnt - t0); end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL baseline_drain got %0d left exp 0", sb.size()); end
  endtask

  task automatic test_inversion();
    int t0;
    INV = 1; PED = 100; PRESAMP = 2; WINLEN = 4;
    settle(3995);
    t0 = trig_cnt;
    add(3995, 40); add(3895, 1); add(3995, 20);
    expect_event(40, 2, 4);
    run_part(0, stim.size()); stim.delete();
    checks++; if (trig_cnt - t0 != 1) begin errors++; $display("[TB] FAIL inv_on_trigs got %0d exp 1", trig_cnt - t0); end
    INV = 0; PED = 3995;
    settle(3995);
    t0 = trig_cnt;
    add(3995, 20); add(3895, 1); add(3995, 20);
    run_part(0, stim.size()); stim.delete();
    checks++; if (trig_cnt - t0 != 0) begin errors++; $display("[TB] FAIL inv_off_trigs got %0d exp 0", trig_cnt - t0); end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL inv_drain got %0d left exp 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int t0;
    INV = 0; PED = 100; PRESAMP = 2; WINLEN = 10;
    settle(100);
    t0 = trig_cnt;
    add(100, 40); add(200, 1); add(100, 2); add(200, 1); add(100, 25);
    expect_event(40, 2, 10);
    run_part(0, 48);
    PRESAMP = 15; WINLEN = 1; INHIBIT = 1;
    run_part(48, stim.size()); stim.delete();
    INHIBIT = 0; PRESAMP = 2; WINLEN = 4;
    checks++; if (trig_cnt - t0 != 1) begin errors++; $display("[TB] FAIL busy_trigs got %0d exp 1", trig_cnt - t0); end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL busy_drain got %0d left exp 0", sb.size()); end
  endtask

  task automatic test_inhibit();
    int t0;
    settle(100);
    INHIBIT = 1;
    t0 = trig_cnt;
    add(100, 10); add(200, 1); add(100, 10);
    run_part(0, stim.size()); stim.delete();
    INHIBIT = 0;
    add(100, 10);
    run_part(0, stim.size()); stim.delete();
    checks++; if (trig_cnt - t0 != 0) begin errors++; $display("[TB] FAIL inhibit_trigs got %0d exp 0", trig_cnt - t0); end
  endtask

  task automatic test_edges();
    int t0;
    PRESAMP = 0; WINLEN = 0;
    settle(100);
    t0 = trig_cnt;
    add(100, 40); add(200, 1); add(100, 15);
    expect_event(40, 0, 0);
    run_part(0, stim.size()); stim.delete();
    checks++; if (trig_cnt - t0 != 1) begin errors++; $display("[TB] FAIL winlen0_trigs got %0d exp 1", trig_cnt - t0); end
    PRESAMP = 15; WINLEN = 3;
    settle(100);
    t0 = trig_cnt;
    for (int i = 0; i < 40; i++) add(100 + (i % 30), 1);
    add(200, 1); add(100, 20);
    expect_event(40, 15, 3);
    run_part(0, stim.size()); stim.delete();
    checks++; if (trig_cnt - t0 != 1) begin errors++; $display("[TB] FAIL presamp15_trigs got %0d exp 1", trig_cnt - t0); end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL edges_drain got %0d left exp 0", sb.size()); end
  endtask

  task automatic test_reset_fill();
    int t0;
    PRESAMP = 0; WINLEN = 20;
    settle(100);
    add(100, 40); add(200, 1); add(100, 8);
    expect_event(40, 0, 20);
    run_part(0, stim.size()); stim.delete();
    checks++; if (DVALID !== 1'b1) begin errors++; $display("[TB] FAIL mid_readout_dvalid got %b exp 1", DVALID); end
    RST = 1'b1;
    tick();
    checks++; if (DVALID !== 1'b0) begin errors++; $display("[TB] FAIL abort_dvalid got %b exp 0", DVALID); end
    checks++; if (DOUT !== 16'd0) begin errors++; $display("[TB] FAIL abort_dout got %h exp 0", DOUT); end
    RST = 1'b0;
    sb.delete();
    exp_cnt = 0;
    DIN = 12'd100;
    tick();
    checks++; if (DVALID !== 1'b0) begin errors++; $display("[TB] FAIL abort_resume got %b exp 0", DVALID); end
    PRESAMP = 2; WINLEN = 4;
    t0 = trig_cnt;
    add(100, 19); add(200, 1); add(100, 20); add(200, 1); add(100, 20);
    expect_event(40, 2, 4);
    run_part(0, stim.size()); stim.delete();
    checks++; if (trig_cnt - t0 != 1) begin errors++; $display("[TB] FAIL fill_trigs got %0d exp 1", trig_cnt - t0); end
    checks++; if (last_hdr !== 16'h8000) begin errors++; $display("[TB] FAIL fill_header got %h exp 8000", last_hdr); end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL fill_drain got %0d left exp 0", sb.size()); end
  endtask

  task automatic test_wrap();
    int t0;
    do_reset();
    PRESAMP = 0; WINLEN = 1;
    settle(100);
    t0 = trig_cnt;
    add(100, 40);
    for (int m = 0; m < 16385; m++) begin
      add(200, 1);
      expect_event(stim.size() - 1, 0, 1);
      add(100, 2);
    end
    add(100, 10);
    run_part(0, stim.size()); stim.delete();
    checks++; if (trig_cnt - t0 != 16385) begin errors++; $display("[TB] FAIL wrap_trigs got %0d exp 16385", trig_cnt - t0); end
    checks++; if (last_hdr !== 16'h8000) begin errors++; $display("[TB] FAIL wrap_last_header got %h exp 8000", last_hdr); end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL wrap_drain got %0d left exp 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_inversion();
    test_back_to_back();
    test_inhibit();
    test_edges();
    test_reset_fill();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
